// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage owning the PC and the F/D pipeline register
module fetch_unit #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter logic [15:0] BUBBLE_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic [31:0] F_out,
  output logic        F_valid,
  output logic        halted,
  output logic [15:0] pc
);
  typedef enum logic [2:0] {IDLE, FETCH, DROP, HOLD, HALT} state_t;
  localparam logic [31:0] BUBBLE = {16'h0000, BUBBLE_INSTR};
  state_t state, state_n;
  logic [15:0] req_addr, req_addr_n, pc_n, pc_inc;
  logic [31:0] f_out_n, hold_data, hold_data_n;
  logic f_valid_n, hold_hlt, hold_hlt_n, redirect, is_hlt;
  assign pc_inc    = pc + 16'd2;
  assign redirect  = flush & ~stall;
  assign is_hlt    = imem_data[15:12] == 4'hF;
  assign imem_req  = state == FETCH || state == DROP;
  assign imem_addr = req_addr;
  assign halted    = state == HALT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      F_out     <= BUBBLE;
      F_valid   <= 1'b0;
      hold_data <= 32'h0;
      hold_hlt  <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      req_addr  <= req_addr_n;
      F_out     <= f_out_n;
      F_valid   <= f_valid_n;
      hold_data <= hold_data_n;
      hold_hlt  <= hold_hlt_n;
    end
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    req_addr_n  = req_addr;
    f_out_n     = stall ? F_out : BUBBLE;
    f_valid_n   = stall & F_valid;
    hold_data_n = hold_data;
    hold_hlt_n  = hold_hlt;
    case (state)
      IDLE: begin
        state_n    = FETCH;
        req_addr_n = pc;
      end
      FETCH:
        if (redirect) begin
          // a response arriving with the flush is squashed; otherwise it must still be drained
          pc_n       = branch_target;
          req_addr_n = imem_ready ? branch_target : req_addr;
          state_n    = imem_ready ? FETCH : DROP;
        end else if (imem_ready) begin
          pc_n = pc_inc;
          if (stall) begin
            hold_data_n = {pc_inc, imem_data};
            hold_hlt_n  = is_hlt;
            state_n     = HOLD;
          end else begin
            f_out_n    = {pc_inc, imem_data};
            f_valid_n  = 1'b1;
            req_addr_n = pc_inc;
            state_n    = is_hlt ? HALT : FETCH;
          end
        end
      DROP: begin
        pc_n = redirect ? branch_target : pc;
        if (imem_ready) begin
          req_addr_n = redirect ? branch_target : pc;
          state_n    = FETCH;
        end
      end
      HOLD:
        if (!stall) begin
          f_out_n    = hold_data;
          f_valid_n  = 1'b1;
          req_addr_n = pc;
          state_n    = hold_hlt ? HALT : FETCH;
        end
      HALT:
        if (redirect) begin
          pc_n       = branch_target;
          req_addr_n = branch_target;
          state_n    = FETCH;
        end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table for the fetch corner cases plus a scoreboarded random-latency stream
module tb_fetch_unit;
  localparam logic [31:0] B = 32'h0000_0E00;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0, imem_ready = 1'b0;
  logic [15:0] branch_target = 16'h0, imem_data = 16'h0;
  logic imem_req, F_valid, halted;
  logic [15:0] imem_addr, pc;
  logic [31:0] F_out;
  int tests = 0, fails = 0;
  typedef struct packed {
    logic s, f;
    logic [15:0] tgt;
    logic r;
    logic [15:0] d;
    logic req;
    logic [15:0] addr;
    logic h;
    logic [31:0] fout;
    logic fv;
  } vec_t;
  vec_t tbl[$];
  logic [31:0] sb[$];
  fetch_unit #(.RESET_PC(16'h0000), .BUBBLE_INSTR(16'h0E00)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_data(imem_data),
    .F_out(F_out), .F_valid(F_valid), .halted(halted), .pc(pc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  function automatic vec_t mk(input logic s, f, input logic [15:0] tgt, input logic r,
                              input logic [15:0] d, input logic req, input logic [15:0] addr,
                              input logic h, input logic [31:0] fout, input logic fv);
    return '{s, f, tgt, r, d, req, addr, h, fout, fv};
  endfunction
  function automatic logic [15:0] mdata(input logic [15:0] a);
    return {4'h3, a[11:0] ^ 12'hABC};
  endfunction
  initial begin
    logic [15:0] exp_addr;
    logic busy;
    int lat;
    //          s  f  tgt       r  data      req addr      h  F_out          fv
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, B,             0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h1123, 1, 16'h0000, 0, 32'h0002_1123, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h2456, 1, 16'h0002, 0, 32'h0004_2456, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 0, B,             0));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 16'h3789, 1, 16'h0004, 0, B,             0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0004, 0, B,             0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0004, 0, 32'h0006_3789, 1));
    tbl.push_back(mk(0, 1, 16'h0040, 0, 16'h0000, 1, 16'h0006, 0, B,             0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0006, 0, B,             0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h1AAA, 1, 16'h0006, 0, B,             0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h4111, 1, 16'h0040, 0, 32'h0042_4111, 1));
    tbl.push_back(mk(0, 1, 16'h0080, 1, 16'h5222, 1, 16'h0042, 0, B,             0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'hF000, 1, 16'h0080, 0, 32'h0082_F000, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0082, 1, B,             0));
    tbl.push_back(mk(1, 1, 16'h0010, 0, 16'h0000, 0, 16'h0082, 1, B,             0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0082, 1, B,             0));
    tbl.push_back(mk(0, 1, 16'h0010, 0, 16'h0000, 0, 16'h0082, 1, B,             0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h6333, 1, 16'h0010, 0, 32'h0012_6333, 1));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0012, 0, 32'h0012_6333, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0012, 0, B,             0));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 16'hF123, 1, 16'h0012, 0, B,             0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0012, 0, 32'h0014_F123, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0014, 1, B,             0));
    tbl.push_back(mk(0, 1, 16'hFFFE, 0, 16'h0000, 0, 16'h0014, 1, B,             0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0777, 1, 16'hFFFE, 0, 32'h0000_0777, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, B,             0));
    repeat (2) @(posedge clk);
    #1;
    chk("rst req", imem_req, 0);
    chk("rst addr", imem_addr, 16'h0000);
    chk("rst pc", pc, 16'h0000);
    chk("rst F_out", F_out, B);
    chk("rst F_valid", F_valid, 0);
    chk("rst halted", halted, 0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      {stall, flush, branch_target, imem_ready, imem_data} = {tbl[i].s, tbl[i].f, tbl[i].tgt, tbl[i].r, tbl[i].d};
      #1;
      chk($sformatf("v%0d req", i), imem_req, tbl[i].req);
      chk($sformatf("v%0d addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("v%0d halted", i), halted, tbl[i].h);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d F_out", i), F_out, tbl[i].fout);
      chk($sformatf("v%0d F_valid", i), F_valid, tbl[i].fv);
    end
    // flush into DROP, re-flush while dropping, then reset mid-transaction
    @(negedge clk);
    {stall, flush, branch_target, imem_ready, imem_data} = {1'b0, 1'b1, 16'h0040, 1'b0, 16'h0};
    #1 chk("drop pre req", imem_req, 1);
    @(posedge clk);
    #1 chk("drop pc", pc, 16'h0040);
    @(negedge clk);
    branch_target = 16'h0060;
    #1 chk("drop req", imem_req, 1);
    chk("drop addr", imem_addr, 16'h0000);
    @(posedge clk);
    #1 chk("drop reflush pc", pc, 16'h0060);
    chk("drop reflush addr", imem_addr, 16'h0000);
    #1 rst_n = 1'b0;
    flush = 1'b0;
    #1;
    chk("async rst req", imem_req, 0);
    chk("async rst addr", imem_addr, 16'h0000);
    chk("async rst pc", pc, 16'h0000);
    chk("async rst F_out", F_out, B);
    chk("async rst F_valid", F_valid, 0);
    chk("async rst halted", halted, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1 chk("restart idle req", imem_req, 0);
    @(posedge clk);
    #1 chk("restart req", imem_req, 1);
    chk("restart addr", imem_addr, 16'h0000);
    // random-latency, random-stall stream checked through the scoreboard
    exp_addr = 16'h0000;
    busy = 1'b0;
    lat = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      stall = n < 390 && $urandom_range(0, 3) == 0;
      imem_ready = 1'b0;
      imem_data = 16'h0;
      if (imem_req && n < 390) begin
        chk("stream addr", imem_addr, exp_addr);
        if (!busy) begin
          busy = 1'b1;
          lat = $urandom_range(0, 2);
        end
        if (lat == 0) begin
          imem_ready = 1'b1;
          imem_data = mdata(exp_addr);
          sb.push_back({exp_addr + 16'd2, mdata(exp_addr)});
          exp_addr = exp_addr + 16'd2;
          busy = 1'b0;
        end else lat--;
      end
      @(posedge clk);
      #1;
      if (!stall && F_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL stream extra: got F_out %h valid, expected no instruction", F_out);
        end else chk("stream F_out", F_out, sb.pop_front());
      end
    end
    chk("stream drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
